// File: rtl/rv32m_issue_ctrl_if.sv
// Handshake bundle between an issuing core, the RV32M issue controller and
// the external multiplier.
interface rv32m_issue_ctrl_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic        rsp_ready_i;
    logic        busy_o;
    logic        mult_en_o;
    logic [31:0] op_A_o;
    logic [31:0] op_B_o;
    logic        signed_A_o;
    logic        signed_B_o;
    logic        upper_o;
    logic [31:0] mult_result_i;
    logic        mult_done_i;

    modport slave (
        input  req_valid_i, funct3_i, rs1_i, rs2_i, rsp_ready_i, mult_result_i, mult_done_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, busy_o, mult_en_o,
               op_A_o, op_B_o, signed_A_o, signed_B_o, upper_o
    );

    modport master (
        output req_valid_i, funct3_i, rs1_i, rs2_i, rsp_ready_i, mult_result_i, mult_done_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, busy_o, mult_en_o,
               op_A_o, op_B_o, signed_A_o, signed_B_o, upper_o
    );
endinterface

// File: rtl/rv32m_issue_ctrl.sv
// RV32M issue controller: hands MUL* ops to an external multiplier and runs
// DIV*/REM* on an internal 32-cycle restoring divider.
module rv32m_issue_ctrl (
    input  logic               clk_i,
    input  logic               rst_i,
    rv32m_issue_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_RUN  = 2'd2,
        RESP     = 2'd3
    } state_e;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return (~v) + 32'd1;
    endfunction

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? neg32(v) : v;
    endfunction

    state_e      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        busy_q, busy_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        mult_en_q, mult_en_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic        signed_a_q, signed_a_d;
    logic        signed_b_q, signed_b_d;
    logic        upper_q, upper_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dsr_q, dsr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        is_rem_q, is_rem_d;
    logic        quo_neg_q, quo_neg_d;
    logic        rem_neg_q, rem_neg_d;

    logic        div_signed_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic        div_ovf_s;
    logic [32:0] partial_s;
    logic        fits_s;
    logic [31:0] sub_s;
    logic [31:0] rem_next_s;
    logic [31:0] quo_next_s;
    logic [31:0] quo_fix_s;
    logic [31:0] rem_fix_s;

    // Request decode used on acceptance.
    always_comb begin
        div_signed_s = ~bus.funct3_i[0];
        a_neg_s      = div_signed_s & bus.rs1_i[31];
        b_neg_s      = div_signed_s & bus.rs2_i[31];
        div_ovf_s    = div_signed_s && (bus.rs1_i == 32'h8000_0000) && (bus.rs2_i == 32'hFFFF_FFFF);
    end

    // One restoring step: quo_q shifts dividend bits out and quotient bits in.
    always_comb begin
        partial_s  = {rem_q, quo_q[31]};
        fits_s     = (partial_s >= {1'b0, dsr_q});
        sub_s      = partial_s[31:0] - dsr_q;
        rem_next_s = fits_s ? sub_s : partial_s[31:0];
        quo_next_s = {quo_q[30:0], fits_s};
        quo_fix_s  = quo_neg_q ? neg32(quo_next_s) : quo_next_s;
        rem_fix_s  = rem_neg_q ? neg32(rem_next_s) : rem_next_s;
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        rsp_data_d = rsp_data_q;
        mult_en_d  = 1'b0;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        signed_a_d = signed_a_q;
        signed_b_d = signed_b_q;
        upper_d    = upper_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dsr_d      = dsr_q;
        cnt_d      = cnt_q;
        is_rem_d   = is_rem_q;
        quo_neg_d  = quo_neg_q;
        rem_neg_d  = rem_neg_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    if (!bus.funct3_i[2]) begin
                        state_d    = MUL_WAIT;
                        mult_en_d  = 1'b1;
                        op_a_d     = bus.rs1_i;
                        op_b_d     = bus.rs2_i;
                        signed_a_d = (bus.funct3_i == 3'b001) || (bus.funct3_i == 3'b010);
                        signed_b_d = (bus.funct3_i == 3'b001);
                        upper_d    = (bus.funct3_i != 3'b000);
                    end else if (bus.rs2_i == 32'd0) begin
                        state_d    = RESP;
                        rsp_data_d = bus.funct3_i[1] ? bus.rs1_i : 32'hFFFF_FFFF;
                    end else if (div_ovf_s) begin
                        state_d    = RESP;
                        rsp_data_d = bus.funct3_i[1] ? 32'h0000_0000 : 32'h8000_0000;
                    end else begin
                        state_d    = DIV_RUN;
                        quo_d      = mag32(bus.rs1_i, div_signed_s);
                        dsr_d      = mag32(bus.rs2_i, div_signed_s);
                        rem_d      = 32'd0;
                        cnt_d      = 5'd0;
                        is_rem_d   = bus.funct3_i[1];
                        quo_neg_d  = a_neg_s ^ b_neg_s;
                        rem_neg_d  = a_neg_s;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            MUL_WAIT: begin
                if (bus.mult_done_i) begin
                    state_d    = RESP;
                    rsp_data_d = bus.mult_result_i;
                end else begin
                    state_d = MUL_WAIT;
                end
            end
            DIV_RUN: begin
                quo_d = quo_next_s;
                rem_d = rem_next_s;
                cnt_d = cnt_q + 5'd1;
                // The 32nd step's result goes straight to the response register.
                if (cnt_q == 5'd31) begin
                    state_d    = RESP;
                    rsp_data_d = is_rem_q ? rem_fix_s : quo_fix_s;
                end else begin
                    state_d = DIV_RUN;
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            mult_en_q   <= 1'b0;
            op_a_q      <= 32'd0;
            op_b_q      <= 32'd0;
            signed_a_q  <= 1'b0;
            signed_b_q  <= 1'b0;
            upper_q     <= 1'b0;
            quo_q       <= 32'd0;
            rem_q       <= 32'd0;
            dsr_q       <= 32'd0;
            cnt_q       <= 5'd0;
            is_rem_q    <= 1'b0;
            quo_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            mult_en_q   <= mult_en_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            signed_a_q  <= signed_a_d;
            signed_b_q  <= signed_b_d;
            upper_q     <= upper_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dsr_q       <= dsr_d;
            cnt_q       <= cnt_d;
            is_rem_q    <= is_rem_d;
            quo_neg_q   <= quo_neg_d;
            rem_neg_q   <= rem_neg_d;
        end
    end

    assign bus.req_ready_o = req_ready_q;
    assign bus.busy_o      = busy_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_data_o  = rsp_data_q;
    assign bus.mult_en_o   = mult_en_q;
    assign bus.op_A_o      = op_a_q;
    assign bus.op_B_o      = op_b_q;
    assign bus.signed_A_o  = signed_a_q;
    assign bus.signed_B_o  = signed_b_q;
    assign bus.upper_o     = upper_q;

endmodule

// File: tb/tb_rv32m_issue_ctrl.sv
// Randomized self-checking bench for rv32m_issue_ctrl with a transaction-level
// reference model and a few hand-computed directed cases.
module tb_rv32m_issue_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    rv32m_issue_ctrl_if bus();

    rv32m_issue_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    localparam int NEVER = 32'h7FFF_FFFF;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [2:0] mul_flags(input logic [2:0] f3);
        case (f3)
            3'd0:    return 3'b000;
            3'd1:    return 3'b111;
            3'd2:    return 3'b101;
            3'd3:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint pa, pb, p;
        logic [63:0] pv;
        pa = (f3 == 3'd1 || f3 == 3'd2) ? longint'({{32{a[31]}}, a}) : longint'({32'd0, a});
        pb = (f3 == 3'd1) ? longint'({{32{b[31]}}, b}) : longint'({32'd0, b});
        p  = pa * pb;
        pv = p;
        return (f3 == 3'd0) ? pv[31:0] : pv[63:32];
    endfunction

    function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (f3[0]) begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end else begin
            sa = longint'({{32{a[31]}}, a});
            sb = longint'({{32{b[31]}}, b});
        end
        q   = sa / sb;
        r   = sa % sb;
        res = f3[1] ? r : q;
        return res[31:0];
    endfunction

    function automatic int div_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Reference model: one outstanding op, described by when it was issued,
    // when its response becomes visible and what value it carries.
    bit          m_rst_seen = 1'b0;
    bit          m_busy     = 1'b0;
    bit          m_mul_wait = 1'b0;
    bit          m_clean    = 1'b0;
    int          m_rsp_start = NEVER;
    int          m_en_cycle  = -1;
    logic [31:0] m_data = 32'd0;
    logic [2:0]  m_f3   = 3'd0;
    logic [31:0] m_a    = 32'd0;
    logic [31:0] m_b    = 32'd0;

    always @(negedge clk) begin
        bit exp_valid;
        if (m_rst_seen) begin
            exp_valid = m_busy && (cyc >= m_rsp_start);
            chk("req_ready", bus.req_ready_o, !m_busy);
            chk("busy", bus.busy_o, m_busy);
            chk("rsp_valid", bus.rsp_valid_o, exp_valid);
            chk("mult_en", bus.mult_en_o, cyc == m_en_cycle);
            if (exp_valid) chk("rsp_data", bus.rsp_data_o, m_data);
            if (m_busy && m_mul_wait) begin
                chk("op_A", bus.op_A_o, m_a);
                chk("op_B", bus.op_B_o, m_b);
                chk("mul_flags", {bus.signed_A_o, bus.signed_B_o, bus.upper_o}, mul_flags(m_f3));
            end
            if (m_clean) begin
                chk("clean_ops", {bus.op_A_o | bus.op_B_o | bus.rsp_data_o}, 32'd0);
                chk("clean_flags", {bus.signed_A_o, bus.signed_B_o, bus.upper_o}, 3'b000);
            end
        end
        if (rst) begin
            m_rst_seen  = 1'b1;
            m_busy      = 1'b0;
            m_mul_wait  = 1'b0;
            m_clean     = 1'b1;
            m_rsp_start = NEVER;
            m_en_cycle  = -1;
        end else if (m_rst_seen) begin
            if (m_busy) begin
                if (m_mul_wait && bus.mult_done_i) begin
                    m_mul_wait  = 1'b0;
                    m_data      = bus.mult_result_i;
                    m_rsp_start = cyc + 1;
                end else if (cyc >= m_rsp_start && bus.rsp_ready_i) begin
                    m_busy = 1'b0;
                end
            end else if (bus.req_valid_i) begin
                m_busy  = 1'b1;
                m_clean = 1'b0;
                m_f3    = bus.funct3_i;
                m_a     = bus.rs1_i;
                m_b     = bus.rs2_i;
                if (!m_f3[2]) begin
                    m_mul_wait  = 1'b1;
                    m_en_cycle  = cyc + 1;
                    m_rsp_start = NEVER;
                end else begin
                    m_data      = ref_div(m_f3, m_a, m_b);
                    m_rsp_start = cyc + div_latency(m_f3, m_a, m_b);
                end
            end
        end
    end

    task automatic gen_req(output logic [2:0] f3, output logic [31:0] a, output logic [31:0] b);
        f3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 9))
            0:       a = 32'h8000_0000;
            1:       a = 32'($urandom_range(0, 20));
            2:       a = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
            default: a = $urandom;
        endcase
        case ($urandom_range(0, 9))
            0, 1:    b = 32'd0;
            2:       b = 32'hFFFF_FFFF;
            3:       b = 32'($urandom_range(1, 20));
            default: b = $urandom;
        endcase
    endtask

    // Waits for the request to be taken; returns positioned 1 ns into T+1.
    task automatic wait_accept(input bit spurious, output bit acc);
        acc = 1'b0;
        for (int k = 0; k < 50 && !acc; k++) begin
            if (spurious) begin
                bus.mult_done_i   = ($urandom_range(0, 3) == 0);
                bus.mult_result_i = $urandom;
            end
            @(negedge clk);
            acc = bus.req_ready_o;
            @(posedge clk); #1;
        end
        bus.mult_done_i = 1'b0;
        chk("accept_timeout", acc, 1'b1);
    endtask

    task automatic directed(input string nm, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input int lat, input logic [31:0] lit,
                            input int dly, input logic [2:0] flags, input int stall);
        bit acc;
        bus.rsp_ready_i = 1'b0;
        bus.req_valid_i = 1'b1;
        bus.funct3_i    = f3;
        bus.rs1_i       = a;
        bus.rs2_i       = b;
        wait_accept(1'b0, acc);
        bus.req_valid_i = 1'b0;
        if (!f3[2]) begin
            for (int k = 0; k <= dly; k++) begin
                if (k == dly) begin
                    bus.mult_done_i   = 1'b1;
                    bus.mult_result_i = lit;
                end
                @(negedge clk);
                if (k == 0) begin
                    chk({nm, "_en"}, bus.mult_en_o, 1'b1);
                    chk({nm, "_flags"}, {bus.signed_A_o, bus.signed_B_o, bus.upper_o}, flags);
                end else begin
                    chk({nm, "_en_once"}, bus.mult_en_o, 1'b0);
                end
                @(posedge clk); #1;
                bus.mult_done_i = 1'b0;
            end
        end else begin
            for (int k = 1; k < lat; k++) begin
                @(negedge clk);
                chk({nm, "_early"}, bus.rsp_valid_o, 1'b0);
                @(posedge clk); #1;
            end
        end
        for (int s = 0; s <= stall; s++) begin
            if (s == stall) bus.rsp_ready_i = 1'b1;
            @(negedge clk);
            chk({nm, "_valid"}, bus.rsp_valid_o, 1'b1);
            chk({nm, "_data"}, bus.rsp_data_o, lit);
            if (s < stall) chk({nm, "_stall"}, {bus.req_ready_o, bus.busy_o}, 2'b01);
            @(posedge clk); #1;
        end
        bus.rsp_ready_i = 1'b0;
        @(negedge clk);
        chk({nm, "_idle"}, {bus.req_ready_o, bus.busy_o, bus.rsp_valid_o}, 3'b100);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [2:0]  f3, nf3;
        logic [31:0] a, b, na, nb;
        bit          acc, got, eager, pre, seen;

        bus.req_valid_i   = 1'b0;
        bus.funct3_i      = 3'd0;
        bus.rs1_i         = 32'd0;
        bus.rs2_i         = 32'd0;
        bus.rsp_ready_i   = 1'b0;
        bus.mult_result_i = 32'd0;
        bus.mult_done_i   = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", bus.req_ready_o, 1'b1);
        chk("reset_busy", bus.busy_o, 1'b0);
        chk("reset_valid", bus.rsp_valid_o, 1'b0);
        @(posedge clk); #1;

        directed("mulhu",     3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0,  32'hFFFF_FFFE, 3, 3'b001, 0);
        directed("mul",       3'b000, 32'd7,         32'd6,         0,  32'd42,        0, 3'b000, 0);
        directed("mulh",      3'b001, 32'hFFFF_FFFF, 32'd2,         0,  32'hFFFF_FFFF, 1, 3'b111, 0);
        directed("mulhsu",    3'b010, 32'hFFFF_FFFF, 32'd2,         0,  32'hFFFF_FFFF, 2, 3'b101, 0);
        directed("div_neg",   3'b100, 32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFD, 0, 3'b000, 0);
        directed("rem_neg",   3'b110, 32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFF, 0, 3'b000, 0);
        directed("divu_zero", 3'b101, 32'h1234_5678, 32'd0,         1,  32'hFFFF_FFFF, 0, 3'b000, 0);
        directed("remu_zero", 3'b111, 32'd5,         32'd0,         1,  32'd5,         0, 3'b000, 0);
        directed("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1,  32'h8000_0000, 0, 3'b000, 0);
        directed("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1,  32'd0,         0, 3'b000, 0);
        directed("divu_bp",   3'b101, 32'd100,       32'd7,         33, 32'd14,        0, 3'b000, 5);
        directed("remu",      3'b111, 32'd100,       32'd7,         33, 32'd2,         0, 3'b000, 0);

        pre = 1'b0;
        f3 = 3'd0; a = 32'd0; b = 32'd0;
        for (int t = 0; t < 150; t++) begin
            if (!pre) begin
                repeat ($urandom_range(0, 3)) begin
                    bus.mult_done_i   = ($urandom_range(0, 3) == 0);
                    bus.mult_result_i = $urandom;
                    bus.rsp_ready_i   = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                gen_req(f3, a, b);
                bus.req_valid_i = 1'b1;
                bus.funct3_i    = f3;
                bus.rs1_i       = a;
                bus.rs2_i       = b;
            end
            wait_accept(1'b1, acc);
            bus.req_valid_i = 1'b0;
            bus.funct3_i    = 3'($urandom_range(0, 7));
            bus.rs1_i       = $urandom;
            bus.rs2_i       = $urandom;
            if (!f3[2]) begin
                repeat ($urandom_range(0, 4)) begin
                    bus.rsp_ready_i   = 1'($urandom_range(0, 1));
                    bus.mult_result_i = $urandom;
                    @(posedge clk); #1;
                end
                bus.mult_done_i   = 1'b1;
                bus.mult_result_i = ref_mul(f3, a, b);
                @(posedge clk); #1;
                bus.mult_done_i = 1'b0;
            end
            eager = ($urandom_range(0, 3) == 0);
            gen_req(nf3, na, nb);
            got = 1'b0;
            for (int k = 0; k < 60 && !got; k++) begin
                bus.rsp_ready_i   = ($urandom_range(0, 2) != 0);
                bus.mult_done_i   = ($urandom_range(0, 7) == 0);
                bus.mult_result_i = $urandom;
                if (eager) begin
                    bus.req_valid_i = 1'b1;
                    bus.funct3_i    = nf3;
                    bus.rs1_i       = na;
                    bus.rs2_i       = nb;
                end
                @(negedge clk);
                got = bus.rsp_valid_o && bus.rsp_ready_i;
                @(posedge clk); #1;
            end
            chk("rsp_timeout", got, 1'b1);
            bus.mult_done_i = 1'b0;
            pre = eager;
            f3 = nf3; a = na; b = nb;
        end
        bus.req_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        repeat (40) @(posedge clk);
        #1;

        // Reset in the 10th divider cycle: no response may follow.
        bus.req_valid_i = 1'b1;
        bus.funct3_i    = 3'b100;
        bus.rs1_i       = 32'd1000;
        bus.rs2_i       = 32'd7;
        wait_accept(1'b0, acc);
        bus.req_valid_i = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("div_abort_ready", bus.req_ready_o, 1'b1);
        chk("div_abort_busy", bus.busy_o, 1'b0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen = seen | bus.rsp_valid_o;
        end
        chk("div_abort_no_rsp", seen, 1'b0);
        @(posedge clk); #1;

        // Request presented together with reset is not taken.
        bus.req_valid_i = 1'b1;
        bus.funct3_i    = 3'b000;
        bus.rs1_i       = 32'd3;
        bus.rs2_i       = 32'd4;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        chk("rst_accept_en", bus.mult_en_o, 1'b0);
        chk("rst_accept_busy", bus.busy_o, 1'b0);
        @(posedge clk); #1;

        // Reset during MUL_WAIT, then a late done pulse must be ignored.
        bus.req_valid_i = 1'b1;
        wait_accept(1'b0, acc);
        bus.req_valid_i = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.mult_done_i   = 1'b1;
        bus.mult_result_i = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.mult_done_i = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | bus.rsp_valid_o | bus.mult_en_o;
        end
        chk("mul_abort_quiet", seen, 1'b0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rv32m_issue_ctrl.md
RV32M_ISSUE_CTRL -- requirements
Module: rv32m_issue_ctrl

Interface
REQ-001 SHALL have no parameters; one clock clk_i; reset rst_i synchronous, active-high.
REQ-002 clk_i  input  1  clock, all state on rising edge.
REQ-003 rst_i  input  1  synchronous active-high reset.
REQ-004 req_valid_i  input  1  M-extension request valid.
REQ-005 req_ready_o  output  1  request accepted when req_valid_i && req_ready_o.
REQ-006 funct3_i  input  3  RV32M funct3 (000 MUL .. 111 REMU).
REQ-007 rs1_i  input  32  operand A (dividend for div ops).
REQ-008 rs2_i  input  32  operand B (divisor for div ops).
REQ-009 rsp_valid_o  output  1  result valid.
REQ-010 rsp_data_o  output  32  result value.
REQ-011 rsp_ready_i  input  1  consumer accepts result.
REQ-012 busy_o  output  1  high in every state except IDLE.
REQ-013 mult_en_o  output  1  one-cycle start pulse to multiplier.
REQ-014 op_A_o  output  32  multiplier operand A.
REQ-015 op_B_o  output  32  multiplier operand B.
REQ-016 signed_A_o  output  1  operand A signed.
REQ-017 signed_B_o  output  1  operand B signed.
REQ-018 upper_o  output  1  select high product word.
REQ-019 mult_result_i  input  32  multiplier result.
REQ-020 mult_done_i  input  1  multiplier completion strobe.

Function
REQ-021 FSM states SHALL be IDLE, MUL_WAIT, DIV_RUN, RESP; req_ready_o=1 only in IDLE.
REQ-022 On acceptance (cycle T) rs1_i, rs2_i, funct3_i SHALL be latched; funct3_i[2]=0 -> MUL_WAIT, else DIV_RUN or RESP (REQ-027).
REQ-023 Mul mapping (signed_A,signed_B,upper): MUL 0,0,0; MULH 1,1,1; MULHSU 1,0,1; MULHU 0,0,1.
REQ-024 mult_en_o SHALL be high exactly in cycle T+1; op_A_o/op_B_o/signed/upper SHALL stay stable from T+1 until mult_done_i is sampled.
REQ-025 In MUL_WAIT, mult_result_i SHALL be captured in the cycle mult_done_i=1 and state -> RESP; mult_done_i SHALL be ignored in all other states.
REQ-026 Div ops: DIV/REM signed, DIVU/REMU unsigned; quotient rounds toward zero; remainder sign = dividend sign.
REQ-027 Divisor zero: quotient 0xFFFFFFFF, remainder = dividend, rsp_valid_o at T+1, no DIV_RUN.
REQ-028 Signed overflow (0x80000000 / 0xFFFFFFFF, DIV/REM): quotient 0x80000000, remainder 0, rsp_valid_o at T+1.
REQ-029 Otherwise: magnitudes, 32-iteration restoring division one bit/cycle in DIV_RUN (T+1..T+32), sign fix-up, rsp_valid_o at T+33.
REQ-030 In RESP rsp_valid_o=1 and rsp_data_o SHALL hold stable until rsp_ready_i=1; that cycle -> IDLE; no same-cycle re-acceptance (earliest next request accepted one cycle later).
REQ-031 Outside RESP rsp_valid_o=0; mult_en_o=0 outside T+1 of a mul op.

Reset
REQ-032 rst_i=1 SHALL force IDLE and all outputs 0 except req_ready_o=1 (from the first cycle after rst_i deasserts); reset mid-operation aborts with no response and no mult_en_o pulse.

Verification
REQ-033 MULHU 0xFFFFFFFF x 0xFFFFFFFF, model done 3 cycles after mult_en_o returning 0xFFFFFFFE -> signed 0/0, upper 1, single mult_en_o pulse, rsp_data_o 0xFFFFFFFE cycle after done.
REQ-034 DIV rs1=0xFFFFFFF9 (-7) rs2=2 -> 0xFFFFFFFD at T+33; REM same operands -> 0xFFFFFFFF.
REQ-035 DIVU 0x12345678/0 -> 0xFFFFFFFF at T+1; REMU 5/0 -> 0x00000005 at T+1.
REQ-036 DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1; REM -> 0x00000000.
REQ-037 Backpressure: rsp_ready_i low 5 cycles in RESP -> rsp_valid_o and rsp_data_o held, req_ready_o=0, busy_o=1 throughout.
REQ-038 rst_i asserted at DIV_RUN cycle 10 -> rsp_valid_o never rises, req_ready_o=1 and busy_o=0 the cycle after reset deasserts.
